// File: rtl/cnn_pkg.sv
// cnn_pkg: shared pixel width, dimension legality checks and signed max
package cnn_pkg;
  localparam int DATA_W = 8;
  function automatic bit is_even(input int n);
    return n % 2 == 0;
  endfunction
  function automatic bit dim_ok(input int n);
    return n >= 2 && is_even(n);
  endfunction
  function automatic logic signed [31:0] smax(input logic signed [31:0] a, input logic signed [31:0] b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/maxpool_linebuf.sv
// maxpool_linebuf: one row of horizontal maxima, 1 write port, combinational read, no reset
module maxpool_linebuf import cnn_pkg::*; #(
  parameter int DATA_W = cnn_pkg::DATA_W,
  parameter int DEPTH  = 208,
  parameter int AW     = 8
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [AW-1:0]     i_raddr,
  output logic [DATA_W-1:0] o_rdata
);
  logic [DATA_W-1:0] r_mem [DEPTH];
  always_ff @(posedge clk)
    if (i_we) r_mem[i_waddr] <= i_wdata;
  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/maxpool_2x2_stream.sv
// maxpool_2x2_stream: streaming 2x2/stride-2 signed max pooling over a raster feature map
module maxpool_2x2_stream import cnn_pkg::*; #(
  parameter int DATA_W = cnn_pkg::DATA_W,
  parameter int IMG_W  = 416,
  parameter int IMG_H  = 416
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     frame_clr,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic signed [DATA_W-1:0] out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int AW = IMG_W > 2 ? $clog2(IMG_W / 2) : 1;
  localparam logic [CW-1:0] LAST_COL = CW'(IMG_W - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(IMG_H - 1);
  if (!dim_ok(IMG_W) || !dim_ok(IMG_H)) begin : g_bad_dims
    $error("maxpool_2x2_stream: IMG_W and IMG_H must be even and >= 2");
  end
  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic signed [DATA_W-1:0] r_hold, r_out_data, w_lb_rd, w_hmax, w_vmax;
  logic r_out_valid, r_out_last;
  logic w_acc, w_pair, w_emit;
  logic [AW-1:0] w_addr;
  assign in_ready  = !r_out_valid || out_ready;
  assign w_acc     = in_valid && in_ready && !frame_clr;
  assign w_pair    = w_acc && r_col[0];
  assign w_emit    = w_pair && r_row[0];
  assign w_addr    = AW'(r_col >> 1);
  assign w_hmax    = DATA_W'(smax(32'(r_hold), 32'(in_data)));
  assign w_vmax    = DATA_W'(smax(32'(w_lb_rd), 32'(w_hmax)));
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  // even rows park their horizontal maxima; odd rows read them back to close the window
  maxpool_linebuf #(.DATA_W(DATA_W), .DEPTH(IMG_W / 2), .AW(AW)) u_linebuf (
    .clk     (clk),
    .i_we    (w_pair && !r_row[0]),
    .i_waddr (w_addr),
    .i_wdata (w_hmax),
    .i_raddr (w_addr),
    .o_rdata (w_lb_rd)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col       <= '0;
      r_row       <= '0;
      r_hold      <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else if (frame_clr) begin
      r_col       <= '0;
      r_row       <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else begin
      if (w_acc) begin
        r_col <= r_col == LAST_COL ? '0 : r_col + 1'b1;
        if (r_col == LAST_COL) r_row <= r_row == LAST_ROW ? '0 : r_row + 1'b1;
        if (!r_col[0]) r_hold <= in_data;
      end
      if (w_emit) begin
        r_out_data  <= w_vmax;
        r_out_valid <= 1'b1;
        r_out_last  <= r_row == LAST_ROW && r_col == LAST_COL;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_maxpool_2x2_stream.sv
// tb_maxpool_2x2_stream: scoreboard bench with frame-array reference model and directed + random frames
module tb_maxpool_2x2_stream;
  localparam int W = 4, H = 4, DW = 8, N = W * H;
  logic clk = 0, rst_n = 0, frame_clr = 0, in_valid = 0, out_ready = 1;
  logic signed [DW-1:0] in_data = '0;
  logic in_ready, out_valid, out_last;
  logic signed [DW-1:0] out_data;
  int n_vec = 0, n_err = 0;
  int ready_mode = 0;
  logic [DW:0] exp_q[$], got_q[$];
  int pix[H][W];
  int k = 0;
  int fa[N] = '{1, 5, 2, 3, 4, 0, 7, 6, 9, 8, 1, 1, 2, 3, 4, 5};
  int fn[N] = '{-1, -8, -3, -2, -5, -4, -7, -6, -9, -10, -11, -12, -13, -14, -15, -16};
  int f1[N], f2[N];
  maxpool_2x2_stream #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst_n(rst_n), .frame_clr(frame_clr),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
  );
  always #5 clk = ~clk;
  initial forever begin
    @(negedge clk);
    out_ready = ready_mode == 0 ? 1'b1 : ready_mode == 2 ? 1'b0 : ($urandom_range(0, 3) != 0);
  end
  // reference: store accepted pixels at their (row, col) and close a window on each odd/odd pixel
  function automatic void model_accept(int v);
    int r, c, m;
    r = k / W;
    c = k % W;
    pix[r][c] = v;
    if (r % 2 == 1 && c % 2 == 1) begin
      m = pix[r-1][c-1];
      if (pix[r-1][c] > m) m = pix[r-1][c];
      if (pix[r][c-1] > m) m = pix[r][c-1];
      if (pix[r][c] > m) m = pix[r][c];
      exp_q.push_back({1'(k == N - 1), 8'(m)});
    end
    k = (k + 1) % N;
  endfunction
  task automatic chk(string nm, int got, int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    end
  endtask
  initial begin : monitor
    bit stalled = 0;
    logic [DW:0] prev, e;
    forever begin
      @(negedge clk);
      #3;
      if (rst_n) begin
        chk("in_ready", in_ready, !out_valid || out_ready);
        if (out_valid) begin
          if (stalled) chk("stall_hold", {out_last, out_data}, prev);
          if (out_ready) begin
            got_q.push_back({out_last, out_data});
            n_vec++;
            if (exp_q.size() == 0) begin
              n_err++;
              $display("FAIL unexpected_output: got data=%0d last=%0b, expected no output", out_data, out_last);
            end else begin
              e = exp_q.pop_front();
              if ({out_last, out_data} !== e) begin
                n_err++;
                $display("FAIL output: got data=%0d last=%0b, expected data=%0d last=%0b",
                         out_data, out_last, $signed(e[DW-1:0]), e[DW]);
              end
            end
            stalled = 0;
          end else begin
            stalled = 1;
            prev = {out_last, out_data};
          end
        end else stalled = 0;
      end
    end
  end
  task automatic send_pixel(int v);
    bit acc;
    in_valid = 1;
    in_data = 8'(v);
    for (int t = 0; t < 200; t++) begin
      #4;
      acc = in_ready;
      @(posedge clk);
      @(negedge clk);
      if (acc) begin
        model_accept(v);
        in_valid = 0;
        return;
      end
    end
    chk("accept_timeout", 0, 1);
    in_valid = 0;
  endtask
  task automatic send_frame(input int f[N], input bit gaps);
    for (int i = 0; i < N; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
      send_pixel(f[i]);
    end
  endtask
  task automatic rand_frame(output int f[N]);
    for (int i = 0; i < N; i++) f[i] = int'($urandom_range(0, 255)) - 128;
  endtask
  task automatic drain();
    for (int t = 0; t < 100; t++) begin
      if (exp_q.size() == 0 && !out_valid) return;
      @(negedge clk);
    end
    chk("drain_timeout", 0, 1);
  endtask
  task automatic check_reset_state();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_in_ready", in_ready, 1);
  endtask
  task automatic do_reset();
    rst_n = 0;
    in_valid = 0;
    #1;
    check_reset_state();
    repeat (2) @(negedge clk);
    rst_n = 1;
    k = 0;
    exp_q.delete();
  endtask
  task automatic check_pooled(string nm, int base, int e0, int e1, int e2, int e3);
    int ev[4];
    ev = '{e0, e1, e2, e3};
    chk({nm, "_count"}, got_q.size(), base + 4);
    for (int i = 0; i < 4; i++)
      if (base + i < got_q.size()) begin
        chk({nm, "_data"}, int'($signed(got_q[base+i][DW-1:0])), ev[i]);
        chk({nm, "_last"}, got_q[base+i][DW], i == 3);
      end
  endtask
  initial begin
    repeat (2) @(negedge clk);
    #1;
    check_reset_state();
    @(negedge clk);
    rst_n = 1;
    got_q.delete();
    send_frame(fa, 0);
    drain();
    check_pooled("basic", 0, 5, 7, 9, 5);
    got_q.delete();
    send_frame(fn, 1);
    drain();
    check_pooled("negative", 0, -1, -2, -9, -11);
    got_q.delete();
    ready_mode = 2;
    fork
      send_frame(fa, 0);
      begin
        for (int t = 0; t < 200 && !out_valid; t++) @(negedge clk);
        repeat (5) begin
          @(negedge clk);
          #3;
          chk("stall_in_ready", in_ready, 0);
          chk("stall_data", out_data, 5);
        end
        ready_mode = 0;
      end
    join
    drain();
    check_pooled("stall", 0, 5, 7, 9, 5);
    got_q.delete();
    rand_frame(f1);
    rand_frame(f2);
    send_frame(f1, 0);
    send_frame(f2, 0);
    drain();
    chk("b2b_count", got_q.size(), 8);
    for (int i = 0; i < 8 && i < got_q.size(); i++) chk("b2b_last", got_q[i][DW], i % 4 == 3);
    for (int i = 0; i < 6; i++) send_pixel(fa[N-1-i]);
    do_reset();
    got_q.delete();
    send_frame(fa, 0);
    drain();
    check_pooled("after_reset", 0, 5, 7, 9, 5);
    for (int i = 0; i < 3; i++) send_pixel(100 + i);
    in_valid = 1;
    in_data = 8'sd99;
    frame_clr = 1;
    @(posedge clk);
    @(negedge clk);
    frame_clr = 0;
    in_valid = 0;
    k = 0;
    exp_q.delete();
    got_q.delete();
    send_frame(fa, 0);
    drain();
    check_pooled("frame_clr", 0, 5, 7, 9, 5);
    ready_mode = 1;
    for (int fr = 0; fr < 15; fr++) begin
      rand_frame(f1);
      send_frame(f1, fr % 2 == 1);
    end
    ready_mode = 0;
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
